// File: rtl/sram_2port_bank_p.sv
// Two-port SRAM bank with one-hot word-line addressing, read-first reads,
// invalid word-line detection, optional hardwired-zero row 0 and a self-clearing reset.
module sram_2port_bank_p #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 32,
    parameter int ZERO_ROW0 = 1
) (
    input  logic             srclkpos,
    input  logic             reset,
    input  logic [DEPTH-1:0] wordA,
    input  logic [DEPTH-1:0] wordB,
    input  logic             ReadEn,
    input  logic             WriteEnA,
    input  logic             WriteEnB,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic [WIDTH-1:0] outA,
    output logic [WIDTH-1:0] outB,
    output logic             errA,
    output logic             errB,
    output logic             busy
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_ROW = PW'(DEPTH - 1);
    localparam logic          ZR       = (ZERO_ROW0 != 0);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic logic onehot_ok(input logic [DEPTH-1:0] v);
        return ($countones(v) == 32'sd1);
    endfunction

    // Only meaningful when v is one-hot; OR-ing positions keeps it a flat mux.
    function automatic logic [PW-1:0] onehot_idx(input logic [DEPTH-1:0] v);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = idx | (v[i] ? PW'(i) : {PW{1'b0}});
        end
        return idx;
    endfunction

    state_t           state_r, state_s;
    logic [PW-1:0]    ptr_r, ptr_s;
    logic             busy_r;
    logic [WIDTH-1:0] out_a_r, out_b_r;
    logic             err_a_r, err_b_r;
    logic [WIDTH-1:0] mem_r [DEPTH];

    logic             valid_a_s, valid_b_s;
    logic [PW-1:0]    idx_a_s, idx_b_s;
    logic             run_s, clr_s;
    logic             rd_a_s, rd_b_s, wr_a_s, wr_b_s;
    logic             err_a_s, err_b_s;
    logic [WIDTH-1:0] rdata_a_s, rdata_b_s;

    // Word-line decode and access qualification for both ports
    always_comb begin
        valid_a_s = onehot_ok(wordA);
        valid_b_s = onehot_ok(wordB);
        idx_a_s   = onehot_idx(wordA);
        idx_b_s   = onehot_idx(wordB);
        run_s     = (state_r == ST_RUN) && !reset;
        clr_s     = (state_r == ST_CLEAR) && !reset;
        rd_a_s    = run_s && ReadEn && valid_a_s;
        rd_b_s    = run_s && ReadEn && valid_b_s;
        wr_a_s    = run_s && WriteEnA && valid_a_s && !(ZR && (idx_a_s == '0));
        wr_b_s    = run_s && WriteEnB && valid_b_s && !(ZR && (idx_b_s == '0));
        err_a_s   = run_s && (ReadEn || WriteEnA) && !valid_a_s;
        err_b_s   = run_s && (ReadEn || WriteEnB) && !valid_b_s;
        rdata_a_s = (ZR && (idx_a_s == '0)) ? '0 : mem_r[idx_a_s];
        rdata_b_s = (ZR && (idx_b_s == '0)) ? '0 : mem_r[idx_b_s];
    end

    // Next-state logic: sweep every row in CLEAR, then stay in RUN
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        case (state_r)
            ST_CLEAR: begin
                if (ptr_r == LAST_ROW) begin
                    state_s = ST_RUN;
                    ptr_s   = '0;
                end else begin
                    state_s = ST_CLEAR;
                    ptr_s   = ptr_r + PW'(1);
                end
            end
            ST_RUN: begin
                state_s = ST_RUN;
                ptr_s   = ptr_r;
            end
            default: begin
                state_s = ST_CLEAR;
                ptr_s   = '0;
            end
        endcase
    end

    // State, clear pointer and busy flag
    always_ff @(posedge srclkpos) begin
        if (reset) begin
            state_r <= ST_CLEAR;
            ptr_r   <= '0;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            busy_r  <= (state_s == ST_CLEAR);
        end
    end

    // Registered read data and error flags; data holds unless a valid read lands
    always_ff @(posedge srclkpos) begin
        if (reset) begin
            out_a_r <= '0;
            out_b_r <= '0;
            err_a_r <= 1'b0;
            err_b_r <= 1'b0;
        end else begin
            err_a_r <= err_a_s;
            err_b_r <= err_b_s;
            if (rd_a_s) out_a_r <= rdata_a_s;
            if (rd_b_s) out_b_r <= rdata_b_s;
        end
    end

    // Array writes: port A is applied last so it wins a same-row collision
    always_ff @(posedge srclkpos) begin
        if (clr_s) begin
            mem_r[ptr_r] <= '0;
        end else begin
            if (wr_b_s) mem_r[idx_b_s] <= inB;
            if (wr_a_s) mem_r[idx_a_s] <= inA;
        end
    end

    assign outA = out_a_r;
    assign outB = out_b_r;
    assign errA = err_a_r;
    assign errB = err_b_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_sram_2port_bank_p.sv
// Directed bench for sram_2port_bank_p: a behavioural array model is checked every
// cycle, backed by hand-computed literal expectations and a small 8x4 instance.
module tb_sram_2port_bank_p;

    localparam int W = 16;
    localparam int D = 32;
    localparam int Z = 1;

    logic         clk;
    logic         reset, read_en, we_a, we_b;
    logic [D-1:0] worda, wordb;
    logic [W-1:0] in_a, in_b, out_a, out_b;
    logic         err_a, err_b, busy;

    logic         s_reset, s_re, s_wea, s_web;
    logic [3:0]   s_worda, s_wordb;
    logic [7:0]   s_ina, s_inb, s_outa, s_outb;
    logic         s_erra, s_errb, s_busy;

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model state
    logic [W-1:0] m [D];
    int           clr_left = 0;
    logic [W-1:0] e_oa, e_ob;
    logic         e_ea, e_eb, e_busy;

    sram_2port_bank_p #(.WIDTH(W), .DEPTH(D), .ZERO_ROW0(Z)) dut (
        .srclkpos(clk), .reset(reset), .wordA(worda), .wordB(wordb),
        .ReadEn(read_en), .WriteEnA(we_a), .WriteEnB(we_b),
        .inA(in_a), .inB(in_b), .outA(out_a), .outB(out_b),
        .errA(err_a), .errB(err_b), .busy(busy)
    );

    sram_2port_bank_p #(.WIDTH(8), .DEPTH(4), .ZERO_ROW0(0)) u_small (
        .srclkpos(clk), .reset(s_reset), .wordA(s_worda), .wordB(s_wordb),
        .ReadEn(s_re), .WriteEnA(s_wea), .WriteEnB(s_web),
        .inA(s_ina), .inB(s_inb), .outA(s_outa), .outB(s_outb),
        .errA(s_erra), .errB(s_errb), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [D-1:0] oh(input int r);
        logic [D-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    function automatic int first_set(input logic [D-1:0] v);
        for (int i = 0; i < D; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_step(input logic r, re, wea, web, input logic [D-1:0] a, b,
                              input logic [W-1:0] da, db);
        logic va, vb;
        int   ia, ib;
        if (r) begin
            clr_left = D;
            e_busy = 1'b1; e_oa = '0; e_ob = '0; e_ea = 1'b0; e_eb = 1'b0;
        end else if (clr_left > 0) begin
            clr_left--;
            e_ea = 1'b0; e_eb = 1'b0;
            if (clr_left == 0) begin
                for (int i = 0; i < D; i++) m[i] = '0;
                e_busy = 1'b0;
            end
        end else begin
            va = ($countones(a) == 1);
            vb = ($countones(b) == 1);
            ia = first_set(a);
            ib = first_set(b);
            e_ea = (re || wea) && !va;
            e_eb = (re || web) && !vb;
            if (re && va) e_oa = (Z != 0 && ia == 0) ? '0 : m[ia];
            if (re && vb) e_ob = (Z != 0 && ib == 0) ? '0 : m[ib];
            if (web && vb && !(Z != 0 && ib == 0)) m[ib] = db;
            if (wea && va && !(Z != 0 && ia == 0)) m[ia] = da;
        end
    endtask

    task automatic cyc(input logic r, re, wea, web, input logic [D-1:0] a, b,
                       input logic [W-1:0] da, db);
        reset = r; read_en = re; we_a = wea; we_b = web;
        worda = a; wordb = b; in_a = da; in_b = db;
        model_step(r, re, wea, web, a, b, da, db);
        @(negedge clk);
        chk("busy", {63'd0, busy}, {63'd0, e_busy});
        chk("outA", {48'd0, out_a}, {48'd0, e_oa});
        chk("outB", {48'd0, out_b}, {48'd0, e_ob});
        chk("errA", {63'd0, err_a}, {63'd0, e_ea});
        chk("errB", {63'd0, err_b}, {63'd0, e_eb});
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic wra(input int r, input logic [W-1:0] d);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, oh(r), '0, d, '0);
    endtask

    task automatic rd(input int ra, input int rb);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, oh(ra), oh(rb), '0, '0);
    endtask

    // Reset edge, then count cycles where busy is observed high.
    task automatic clear_seq(input logic poke, output int n);
        cyc(1'b1, 1'b0, poke, 1'b0, oh(13), '0, 16'h3333, '0);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            if (poke && n == 1) begin
                cyc(1'b0, 1'b1, 1'b1, 1'b1, oh(3), oh(3), 16'hABCD, 16'h4321);
                chk("busy_outA_held", {48'd0, out_a}, 64'h0);
            end else begin
                idle();
            end
        end
    endtask

    task automatic readall();
        for (int i = 0; i < D; i++) begin
            rd(i, D - 1 - i);
            chk("clr_rowA", {48'd0, out_a}, 64'h0);
            chk("clr_rowB", {48'd0, out_b}, 64'h0);
        end
    endtask

    initial begin
        int n;
        s_reset = 1'b0; s_re = 1'b0; s_wea = 1'b0; s_web = 1'b0;
        s_worda = 4'd0; s_wordb = 4'd0; s_ina = 8'd0; s_inb = 8'd0;

        // 1: reset clear, garbage preload, busy ignores accesses
        clear_seq(1'b0, n);
        chk("first_busy_edges", 64'(n), 64'd32);
        wra(3, 16'hDEAD);
        wra(20, 16'h0BAD);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, oh(31), '0, 16'hF00D);
        rd(3, 31);
        chk("garbage_rd_A", {48'd0, out_a}, 64'hDEAD);
        chk("garbage_rd_B", {48'd0, out_b}, 64'hF00D);
        clear_seq(1'b1, n);
        chk("busy_edges", 64'(n), 64'd32);
        readall();

        // 2: basic write/read and hardwired row 0
        wra(5, 16'hBEEF);
        rd(0, 5);
        chk("rw_outB", {48'd0, out_b}, 64'hBEEF);
        wra(0, 16'h1234);
        rd(0, 5);
        chk("row0_outA", {48'd0, out_a}, 64'h0);
        chk("row0_errA", {63'd0, err_a}, 64'h0);

        // 3: read-first and write collision
        wra(7, 16'h1111);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, oh(7), oh(5), 16'h2222, '0);
        chk("rdfirst_old", {48'd0, out_a}, 64'h1111);
        rd(7, 7);
        chk("rdfirst_newA", {48'd0, out_a}, 64'h2222);
        chk("rdfirst_newB", {48'd0, out_b}, 64'h2222);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, oh(9), oh(9), 16'hAAAA, 16'h5555);
        rd(9, 9);
        chk("collide_A", {48'd0, out_a}, 64'hAAAA);
        chk("collide_B", {48'd0, out_b}, 64'hAAAA);

        // 4: invalid one-hot word lines
        cyc(1'b0, 1'b1, 1'b0, 1'b0, D'(3), oh(9), '0, '0);
        chk("inv_errA", {63'd0, err_a}, 64'h1);
        chk("inv_outA_held", {48'd0, out_a}, 64'hAAAA);
        chk("inv_errB_ok", {63'd0, err_b}, 64'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, oh(9), '0, '0, 16'h7777);
        chk("zero_errB", {63'd0, err_b}, 64'h1);
        chk("idleA_errA", {63'd0, err_a}, 64'h0);
        idle();
        chk("clr_errA", {63'd0, err_a}, 64'h0);
        chk("clr_errB", {63'd0, err_b}, 64'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, D'(32'h600), '0, 16'h1234, '0);
        chk("multi_wr_errA", {63'd0, err_a}, 64'h1);
        rd(9, 10);
        chk("nowr_row9", {48'd0, out_a}, 64'hAAAA);
        chk("nowr_row10", {48'd0, out_b}, 64'h0);

        // 5: reset mid-CLEAR at ptr=10, then reset during a write burst
        wra(25, 16'hCAFE);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        for (int i = 0; i < 10; i++) idle();
        chk("midclr_busy", {63'd0, busy}, 64'h1);
        clear_seq(1'b0, n);
        chk("midclr_edges", 64'(n), 64'd32);
        readall();
        wra(11, 16'h0101);
        wra(12, 16'h0202);
        clear_seq(1'b1, n);
        chk("burst_edges", 64'(n), 64'd32);
        readall();

        // 6: 8x4 instance with an ordinary row 0
        s_reset = 1'b1;
        idle();
        s_reset = 1'b0;
        n = 0;
        while (s_busy === 1'b1 && n < 100) begin
            n++;
            idle();
        end
        chk("small_busy_edges", 64'(n), 64'd4);
        s_worda = 4'b0001; s_wea = 1'b1; s_ina = 8'h5A;
        idle();
        s_wea = 1'b0; s_re = 1'b1; s_wordb = 4'b0010;
        idle();
        s_re = 1'b0;
        chk("small_row0", {56'd0, s_outa}, 64'h5A);
        chk("small_row1", {56'd0, s_outb}, 64'h0);
        chk("small_errA", {63'd0, s_erra}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
